// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like slave port between the fetch (inst) and
// memory-stage (data) masters. One transaction is outstanding at a time:
// grant -> address handshake -> data return, with the response routed back
// to the master that issued it. Data normally wins ties, but an inst request
// that has been passed over STARVE_LIMIT times in a row gets the next grant.
// Optional feature macro: ARB_INST_CANCEL_EN (in-flight fetch cancel/drop).
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;   // 0 = inst, 1 = data
  logic [3:0] starve_q, starve_d;
  logic       drop;

  logic       data_win;
  logic       sel_data;
  logic       gnt_vld;
  logic       accept;
  logic       resp;

  // Read data is shared; the *_data_ok strobes say whose it is.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

`ifdef ARB_INST_CANCEL_EN
  logic drop_q, drop_d;

  // Remember that the in-flight fetch was cancelled so its return is eaten.
  // The return itself takes priority so a cancel in the same cycle cannot
  // leave a stale drop behind for the next fetch.
  always_comb begin
    drop_d = drop_q;
    if (state_q == DATA && mem_data_ok)
      drop_d = 1'b0;
    else if (inst_cancel && !owner_q && (state_q == ADDR || state_q == DATA))
      drop_d = 1'b1;
  end

  // Drop flag register.
  always_ff @(posedge clk) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= drop_d;
  end

  assign drop = drop_q;
`else
  logic unused_cancel;
  assign unused_cancel = inst_cancel;
  assign drop = 1'b0;
`endif

  // Grant selection, slave request mux, handshake routing and next state.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;

    // Tie-break: data first unless inst has been skipped LIMIT times.
    data_win = data_req && (!inst_req || starve_q != LIMIT);
    // In IDLE the choice is live; once granted it is frozen in owner_q.
    sel_data = (state_q == IDLE) ? data_win : owner_q;
    gnt_vld  = (state_q == ADDR) || (state_q == IDLE && (inst_req || data_req));
    accept   = gnt_vld && mem_addr_ok;
    resp     = (state_q == DATA) && mem_data_ok;

    mem_req   = gnt_vld;
    mem_wr    = 1'b0;
    mem_size  = 2'd2;
    mem_addr  = inst_addr;
    mem_wdata = '0;
    if (sel_data) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end

    inst_addr_ok = accept && !sel_data;
    data_addr_ok = accept && sel_data;
    inst_data_ok = resp && !owner_q && !drop;
    data_data_ok = resp && owner_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = sel_data;
          state_d = mem_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        if (mem_addr_ok) state_d = DATA;
      end
      DATA: begin
        // Stray data_ok outside DATA never reaches here, so it is ignored.
        if (mem_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Count data wins that passed over a waiting fetch; anything else resets.
    if (accept)
      starve_d = (sel_data && inst_req) ? starve_q + 4'd1 : 4'd0;
  end

  // State, owner and starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok, inst_cancel;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the port, whether the slave took the address,
  // how many times in a row a fetch was passed over, and a pending drop.
  bit m_held, m_taken, m_own_data, m_drop;
  int m_skips;

  // Expected accepts (drive the masters' protocol) and DUT observations.
  bit e_iaok, e_daok;
  bit o_iaok, o_daok, o_idok, o_ddok;

`ifdef ARB_INST_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: inputs are already set; check outputs mid-cycle, then advance.
  task automatic tick();
    int  who;   // -1 none, 0 inst, 1 data
    bit  n_held, n_taken, n_own, n_drop;
    int  n_skips;
    #2;
    if (m_taken)     who = -1;
    else if (m_held) who = m_own_data ? 1 : 0;
    else if (data_req && (!inst_req || m_skips != LIM)) who = 1;
    else if (inst_req) who = 0;
    else who = -1;

    e_iaok = (who == 0) && mem_addr_ok;
    e_daok = (who == 1) && mem_addr_ok;

    chk1("mem_req", mem_req, who >= 0);
    if (who == 0) begin
      chk32("mem_addr_i", mem_addr, inst_addr);
      chk1("mem_wr_i", mem_wr, 1'b0);
      chk32("mem_size_i", {30'd0, mem_size}, 32'd2);
      chk32("mem_wdata_i", mem_wdata, 32'd0);
    end else if (who == 1) begin
      chk32("mem_addr_d", mem_addr, data_addr);
      chk1("mem_wr_d", mem_wr, data_wr);
      chk32("mem_size_d", {30'd0, mem_size}, {30'd0, data_size});
      chk32("mem_wdata_d", mem_wdata, data_wdata);
    end
    chk1("inst_addr_ok", inst_addr_ok, e_iaok);
    chk1("data_addr_ok", data_addr_ok, e_daok);
    chk1("inst_data_ok", inst_data_ok, m_taken && !m_own_data && mem_data_ok && !m_drop);
    chk1("data_data_ok", data_data_ok, m_taken && m_own_data && mem_data_ok);
    chk32("inst_rdata", inst_rdata, mem_rdata);
    chk32("data_rdata", data_rdata, mem_rdata);

    o_iaok = inst_addr_ok; o_daok = data_addr_ok;
    o_idok = inst_data_ok; o_ddok = data_data_ok;

    n_held = m_held; n_taken = m_taken; n_own = m_own_data;
    n_drop = m_drop; n_skips = m_skips;
    if (m_taken) begin
      if (mem_data_ok) begin
        n_held = 0; n_taken = 0; n_drop = 0;
      end else if (CANCEL_ON && inst_cancel && !m_own_data) n_drop = 1;
    end else if (who >= 0) begin
      if (CANCEL_ON && m_held && inst_cancel && !m_own_data) n_drop = 1;
      n_held = 1;
      n_own  = (who == 1);
      if (mem_addr_ok) begin
        n_taken = 1;
        n_skips = (who == 1 && inst_req) ? m_skips + 1 : 0;
      end
    end
    if (reset) begin
      n_held = 0; n_taken = 0; n_own = 0; n_drop = 0; n_skips = 0;
    end
    @(posedge clk);
    m_held = n_held; m_taken = n_taken; m_own_data = n_own;
    m_drop = n_drop; m_skips = n_skips;
    @(negedge clk);
  endtask

  task automatic drv(input bit ir, input logic [31:0] ia,
                     input bit dr, input bit dw, input logic [1:0] ds,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input bit aok, input bit dok, input logic [31:0] rd,
                     input bit cn, input bit rs);
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_size = ds; data_addr = da; data_wdata = dwd;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    inst_cancel = cn; reset = rs;
    tick();
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    m_held = 0; m_taken = 0; m_own_data = 0; m_drop = 0; m_skips = 0;

    // Reset, then a stray data_ok in idle must not be forwarded.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    chk1("rst_mem_req", mem_req, 1'b0);

    // Single fetch with immediate accept and next-cycle data.
    drv(1, 32'h34, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk1("t1_iaok", o_iaok, 1'b1);
    drv(0, 32'h34, 0, 0, 0, 0, 0, 0, 1, 32'h2402_0001, 0, 0);
    chk1("t1_idok", o_idok, 1'b1);

    // Simultaneous requests: data first, then inst.
    drv(1, 32'h80, 1, 0, 2, 32'h1000, 0, 1, 0, 0, 0, 0);
    chk1("t2_daok", o_daok, 1'b1);
    chk1("t2_iaok", o_iaok, 1'b0);
    drv(1, 32'h80, 0, 0, 2, 32'h1000, 0, 0, 1, 32'h1111_2222, 0, 0);
    chk1("t2_ddok", o_ddok, 1'b1);
    chk1("t2_idok", o_idok, 1'b0);
    drv(1, 32'h80, 0, 0, 2, 32'h1000, 0, 1, 0, 0, 0, 0);
    chk1("t2_iaok2", o_iaok, 1'b1);
    drv(0, 32'h80, 0, 0, 2, 32'h1000, 0, 0, 1, 32'h3333_4444, 0, 0);

    // Slow address accept on a fetch; data arrives meanwhile and must wait.
    drv(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h200, 1, 1, 1, 32'h300, 32'hAB, 0, 0, 0, 0, 0);
    chk32("t3_addr1", mem_addr, 32'h200);
    drv(1, 32'h200, 1, 1, 1, 32'h300, 32'hAB, 0, 0, 0, 0, 0);
    chk32("t3_addr2", mem_addr, 32'h200);
    drv(1, 32'h200, 1, 1, 1, 32'h300, 32'hAB, 1, 0, 0, 0, 0);
    chk1("t3_iaok", o_iaok, 1'b1);
    drv(0, 32'h200, 1, 1, 1, 32'h300, 32'hAB, 0, 1, 0, 0, 0);
    drv(0, 32'h200, 1, 1, 1, 32'h300, 32'hAB, 1, 0, 0, 0, 0);
    chk1("t3_daok", o_daok, 1'b1);
    drv(0, 32'h200, 0, 1, 1, 32'h300, 32'hAB, 0, 1, 0, 0, 0);

    // Starvation: both held, LIM data grants then one inst grant, repeating.
    for (int k = 0; k < 2 * (LIM + 1); k++) begin
      drv(1, 32'h400 + 32'(4 * k), 1, 0, 2, 32'h2000 + 32'(4 * k), 0, 1, 0, 0, 0, 0);
      chk1("starve_inst", o_iaok, (k % (LIM + 1)) == LIM);
      chk1("starve_data", o_daok, (k % (LIM + 1)) != LIM);
      drv(1, 32'h400, 1, 0, 2, 32'h2000, 0, 0, 1, 32'(k), 0, 0);
    end

    // Cancel in DATA: response eaten only when the feature is built.
    drv(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drv(0, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 32'h600, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0);
    chk1("cancel_idok", o_idok, !CANCEL_ON);
    drv(1, 32'h604, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drv(0, 32'h604, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0);
    chk1("after_cancel_idok", o_idok, 1'b1);

    // Reset in DATA, stray data_ok two cycles later.
    drv(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drv(0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 32'h700, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0);
    chk1("rstd_idok", o_idok, 1'b0);
    chk1("rstd_ddok", o_ddok, 1'b0);
    drv(1, 32'h704, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk1("rstd_idle_iaok", o_iaok, 1'b1);
    drv(0, 32'h704, 0, 0, 0, 0, 0, 0, 1, 32'h88, 0, 0);

    // Random traffic; masters hold requests until the model says accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!inst_req || e_iaok) begin
        inst_req  = $urandom_range(0, 2) != 0;
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req || e_daok) begin
        data_req   = $urandom_range(0, 2) != 0;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = $urandom_range(0, 1) == 0;
      mem_data_ok = $urandom_range(0, 2) == 0;
      mem_rdata   = $urandom;
      inst_cancel = $urandom_range(0, 5) == 0;
      reset       = $urandom_range(0, 99) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master to one-slave arbiter for the CPU's SRAM-like memory interface. It shares a single memory port between the fetch stage's instruction port and the memory stage's data port. It sequences each transaction through grant, address handshake and data return, and routes the response back to the master that issued it. At most one transaction is outstanding on the slave port at any time.

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive data grants allowed while an instruction request waits; must be 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- inst_req  in  1  fetch read request; held until inst_addr_ok.
- inst_addr  in  32  fetch address, word aligned.
- inst_addr_ok  out  1  fetch request accepted.
- inst_rdata  out  32  fetch read data, valid with inst_data_ok.
- inst_data_ok  out  1  fetch data return, 1-cycle pulse.
- inst_cancel  in  1  discard the in-flight fetch response (see Configuration).
- data_req  in  1  load/store request; held until data_addr_ok.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  load/store address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted.
- data_rdata  out  32  load data, valid with data_data_ok.
- data_data_ok  out  1  data return pulse; for stores it marks write completion.
- mem_req, mem_wr, mem_size[1:0], mem_addr[31:0], mem_wdata[31:0]  out  slave request.
- mem_addr_ok, mem_data_ok  in  1  slave handshakes.
- mem_rdata  in  32  slave read data.

## Operation
- FSM states:
  - IDLE: no grant.
  - ADDR: grant held, waiting for mem_addr_ok.
  - DATA: request accepted, waiting for mem_data_ok.
- Register owner: 0 = inst, 1 = data.
- Grant selection in IDLE, combinational:
  - Only one master requesting: that master wins.
  - Both requesting: data wins, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
- starve_cnt is 4 bits. On every accepted grant:
  - Data grant while inst_req = 1: increments.
  - Inst grant: clears.
  - Data grant with inst_req = 0: clears.
- In IDLE and ADDR, mem_* carry the granted master's request; for inst, mem_wr = 0, mem_size = 2 and mem_wdata = 0. With no grant, mem_req = 0.
- mem_addr_ok is forwarded only to the granted master's *_addr_ok.
- IDLE with a request:
  - Capture owner.
  - If mem_addr_ok is 1 the same cycle, go to DATA; else go to ADDR.
- ADDR: the grant is frozen, so a newly arriving data_req does not pre-empt a waiting inst grant. On mem_addr_ok, go to DATA.
- DATA:
  - mem_req = 0.
  - On mem_data_ok, pulse the owner's *_data_ok and return to IDLE.
  - The next grant can issue in the following cycle.
- mem_rdata is wired to both inst_rdata and data_rdata.
- The non-owner's *_addr_ok and *_data_ok are always 0.

## Timing
- Reset values:
  - State IDLE, owner 0, starve_cnt 0, drop 0.
  - mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are all 0.
- Minimum transaction: request and mem_addr_ok in cycle N, mem_data_ok in N+1, next mem_req possible in N+2.
- addr_ok and data_ok paths are combinational pass-through, with zero added latency.
- Back-to-back throughput is one transaction per 2 cycles minimum.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE.
  - A later stray mem_data_ok in IDLE is ignored and is not forwarded.
- mem_data_ok in IDLE or ADDR is ignored.

## Configuration
- ARB_INST_CANCEL_EN defined:
  - inst_cancel = 1 while owner = inst in ADDR or DATA sets the drop register.
  - While drop = 1, the matching mem_data_ok is consumed and not forwarded: inst_data_ok stays 0.
  - drop clears when that mem_data_ok arrives, or on reset.
  - In ADDR the slave request stays asserted until accepted, because slave protocol requires completion.
  - inst_cancel in IDLE, or while owner = data, has no effect.
- ARB_INST_CANCEL_EN not defined:
  - inst_cancel is ignored and the drop register is not built.
  - Every inst response is forwarded.

## Test plan
- Single fetch, inst_addr = 0x34, slave addr_ok immediate, data_ok next cycle with rdata 0x24020001 -> inst_addr_ok in cycle 0, inst_data_ok plus rdata in cycle 1, mem_wr = 0, mem_size = 2.
- inst_req and data_req (load, 0x1000) in the same cycle -> data granted first; inst granted in IDLE after the data return; data_data_ok never pulses inst_data_ok.
- Slave delays addr_ok 3 cycles on an inst grant while data_req rises in the second of those cycles -> mem_addr stays at the inst address through ADDR, and data is granted afterwards.
- STARVE_LIMIT = 4, data_req held continuously with inst_req pending -> 4 data grants, then 1 inst grant, and starve_cnt is back to 0.
- ARB_INST_CANCEL_EN defined: inst_cancel pulsed in DATA -> the following mem_data_ok produces no inst_data_ok, and the next inst request is serviced normally. Undefined: same stimulus -> inst_data_ok pulses.
- Reset asserted in DATA, then mem_data_ok arrives 2 cycles later -> all *_data_ok stay 0, and the FSM stays in IDLE.
